// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM state encoding and address-split width helpers.
package cache_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Word-offset width inside a line.
   function automatic int offset_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Line-index width.
   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   // Remaining upper address bits form the tag.
   function automatic int tag_w(input int awidth, input int sets, input int line_words);
      return awidth - $clog2(sets) - $clog2(line_words);
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Data, tag and valid storage for the cache. Reads are asynchronous.
// A single word write port serves both write hits and line fills; the tag
// and valid bit are written when a fill completes. Only valid bits reset.
module cache_line_array
   import cache_pkg::*;
#(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 16,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 8
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [index_w(SETS)-1:0]                     rd_index,
   input  logic [offset_w(LINE_WORDS)-1:0]              rd_offset,
   output logic [DWIDTH-1:0]                            rd_data,
   output logic [tag_w(AWIDTH,SETS,LINE_WORDS)-1:0]     rd_tag,
   output logic                                         rd_valid,
   input  logic                                         wr_en,
   input  logic [index_w(SETS)-1:0]                     wr_index,
   input  logic [offset_w(LINE_WORDS)-1:0]              wr_offset,
   input  logic [DWIDTH-1:0]                            wr_data,
   input  logic                                         fill_done,
   input  logic [index_w(SETS)-1:0]                     fill_index,
   input  logic [tag_w(AWIDTH,SETS,LINE_WORDS)-1:0]     fill_tag
);

   localparam int OFFSET_W = offset_w(LINE_WORDS);
   localparam int INDEX_W  = index_w(SETS);
   localparam int TAG_W    = tag_w(AWIDTH, SETS, LINE_WORDS);

   logic [DWIDTH-1:0] data_mem [SETS*LINE_WORDS];
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [SETS-1:0]   valid_q;

   assign rd_data  = data_mem[{rd_index, rd_offset}];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid_q[rd_index];

   // Word write: hit update or fill return.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_index, wr_offset}] <= wr_data;
      end
   end

   // Tag captured when the last word of a fill lands.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[fill_index] <= fill_tag;
      end
   end

   // Valid bits: cleared on reset, set on fill completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[fill_index] <= 1'b1;
      end
   end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between
// the CPU load/store stage and a variable-latency backing memory.
// Optional build macro: CACHE_STATS_EN adds saturating hit/miss counters.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | serve read hits, pass writes through, detect read misses
// FILL  | fetch the missing line word by word; stall until last return
module cache_mem_ctrl
   import cache_pkg::*;
#(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 16,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_en,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_valid,
   output logic              stall,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DWIDTH-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   input  logic              mem_rvalid
);

   localparam int OFFSET_W = offset_w(LINE_WORDS);
   localparam int INDEX_W  = index_w(SETS);
   localparam int TAG_W    = tag_w(AWIDTH, SETS, LINE_WORDS);
   localparam int LINE_W   = AWIDTH - OFFSET_W;
   localparam int CNT_W    = OFFSET_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);

   state_t            state, state_nxt;
   logic [LINE_W-1:0] base_line;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  ret_cnt;

   logic [OFFSET_W-1:0] req_offset;
   logic [INDEX_W-1:0]  req_index;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  base_index;
   logic [TAG_W-1:0]    base_tag;

   logic [DWIDTH-1:0]   arr_rd_data;
   logic [TAG_W-1:0]    arr_rd_tag;
   logic                arr_rd_valid;
   logic                hit;

   logic                arr_wr_en;
   logic [INDEX_W-1:0]  arr_wr_index;
   logic [OFFSET_W-1:0] arr_wr_offset;
   logic [DWIDTH-1:0]   arr_wr_data;
   logic                fill_done;
   logic                read_hit;
   logic                read_miss;
   logic                issue_go;

   assign req_offset = req_addr[OFFSET_W-1:0];
   assign req_index  = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign req_tag    = req_addr[AWIDTH-1:OFFSET_W+INDEX_W];
   assign base_index = base_line[INDEX_W-1:0];
   assign base_tag   = base_line[LINE_W-1:INDEX_W];

   assign hit = arr_rd_valid && (arr_rd_tag == req_tag);

   cache_line_array #(
      .DWIDTH    (DWIDTH),
      .AWIDTH    (AWIDTH),
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS)
   ) u_lines (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (req_index),
      .rd_offset (req_offset),
      .rd_data   (arr_rd_data),
      .rd_tag    (arr_rd_tag),
      .rd_valid  (arr_rd_valid),
      .wr_en     (arr_wr_en),
      .wr_index  (arr_wr_index),
      .wr_offset (arr_wr_offset),
      .wr_data   (arr_wr_data),
      .fill_done (fill_done),
      .fill_index(base_index),
      .fill_tag  (base_tag)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: read miss starts a fill, last return ends it.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_en && !req_we && !hit) begin
               state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (mem_rvalid && (ret_cnt == CNT_LAST)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: stall, memory-port muxing and array write steering.
   always_comb begin
      stall         = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      mem_addr      = req_addr;
      mem_wdata     = req_wdata;
      arr_wr_en     = 1'b0;
      arr_wr_index  = req_index;
      arr_wr_offset = req_offset;
      arr_wr_data   = req_wdata;
      fill_done     = 1'b0;
      read_hit      = 1'b0;
      read_miss     = 1'b0;
      issue_go      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_en) begin
               if (req_we) begin
                  mem_wr    = 1'b1;
                  stall     = !mem_ready;
                  arr_wr_en = mem_ready && hit;
               end else if (hit) begin
                  read_hit = 1'b1;
               end else begin
                  stall     = 1'b1;
                  read_miss = 1'b1;
               end
            end
         end
         ST_FILL: begin
            stall         = 1'b1;
            mem_rd        = (issue_cnt < CNT_FULL);
            issue_go      = mem_rd && mem_ready;
            mem_addr      = {base_line, {OFFSET_W{1'b0}}} + AWIDTH'(issue_cnt);
            arr_wr_en     = mem_rvalid;
            arr_wr_index  = base_index;
            arr_wr_offset = ret_cnt[OFFSET_W-1:0];
            arr_wr_data   = mem_rdata;
            fill_done     = mem_rvalid && (ret_cnt == CNT_LAST);
         end
         default: ;
      endcase
   end

   // Fill bookkeeping: line base on miss, issue/return counters during fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_line <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else if (read_miss) begin
         base_line <= req_addr[AWIDTH-1:OFFSET_W];
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else if (state == ST_FILL) begin
         if (issue_go) begin
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (mem_rvalid) begin
            ret_cnt <= ret_cnt + 1'b1;
         end
      end
   end

   // Registered read response, one-cycle pulse after a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= read_hit;
         if (read_hit) begin
            rsp_rdata <= arr_rd_data;
         end
      end
   end

`ifdef CACHE_STATS_EN
   // Saturating hit/miss statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (read_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
            hit_cnt <= hit_cnt + 1'b1;
         end
         if (read_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a 4-cycle in-order backing memory.
module tb_cache_mem_ctrl;

   localparam int LAT = 4;

   logic        clk;
   logic        rst_n;
   logic        req_en;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [15:0] rsp_rdata;
   logic        rsp_valid;
   logic        stall;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   cache_mem_ctrl #(
      .DWIDTH(16), .AWIDTH(16), .SETS(64), .LINE_WORDS(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_en    (req_en),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_rdata (rsp_rdata),
      .rsp_valid (rsp_valid),
      .stall     (stall),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
`ifdef CACHE_STATS_EN
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
`endif
      .mem_rvalid(mem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } rd_t;

   logic [15:0] tb_mem [65536];
   rd_t         rq [$];
   int          cyc;
   int          ready_block;
   int          n_rd, n_wr, n_ret;
   logic [15:0] first_rd_addr, last_rd_addr;
   int          n_tests, n_fail;

   function automatic logic [15:0] init_word(input int a);
      logic [15:0] v;
      v = 16'(a * 7) ^ 16'h3C5A;
      return v;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start of a cycle: present memory-side inputs for this cycle.
   task automatic cyc_begin();
      @(posedge clk);
      #1;
      cyc++;
      mem_ready = (ready_block > 0) ? 1'b0 : 1'b1;
      if (ready_block > 0) ready_block--;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = tb_mem[rq[0].addr];
         void'(rq.pop_front());
         n_ret++;
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 16'hDEAD;
      end
   endtask

   // End of a cycle: record what the backing memory accepts at the next edge.
   task automatic cyc_end();
      rd_t e;
      #1;
      if (mem_rd && mem_ready) begin
         e.addr = mem_addr;
         e.due  = cyc + LAT;
         rq.push_back(e);
         if (n_rd == 0) first_rd_addr = mem_addr;
         last_rd_addr = mem_addr;
         n_rd++;
      end
      if (mem_wr && mem_ready) begin
         tb_mem[mem_addr] = mem_wdata;
         n_wr++;
      end
   endtask

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output int stalls, output int rds, output int wrs,
                         output logic v, output logic [15:0] d);
      int rd0, wr0, guard;
      rd0 = 0; wr0 = n_wr; n_rd = 0;
      stalls = 0; guard = 0;
      cyc_begin();
      req_en = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      cyc_end();
      while (stall && guard < 200) begin
         stalls++; guard++;
         cyc_begin();
         cyc_end();
      end
      check("req_done", stall, 0);
      cyc_begin();
      req_en = 1'b0;
      cyc_end();
      v   = rsp_valid;
      d   = rsp_rdata;
      rds = n_rd - rd0;
      wrs = n_wr - wr0;
   endtask

   int          st, rds, wrs, guard;
   logic        v;
   logic [15:0] d;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; ready_block = 0;
      n_rd = 0; n_wr = 0; n_ret = 0;
      first_rd_addr = '0; last_rd_addr = '0;
      for (int i = 0; i < 65536; i++) tb_mem[i] = init_word(i);
      rst_n = 1'b0; req_en = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;

      // 1: cold read miss, full line fill
      do_req(1'b0, 16'h0000, 16'h0, st, rds, wrs, v, d);
      check("t1_stall_cycles", st, 13);
      check("t1_mem_rd_cnt", rds, 8);
      check("t1_first_addr", first_rd_addr, 16'h0000);
      check("t1_last_addr", last_rd_addr, 16'h0007);
      check("t1_rsp_valid", v, 1);
      check("t1_rdata", d, init_word(0));

      // 2: hit in the freshly filled line
      do_req(1'b0, 16'h0003, 16'h0, st, rds, wrs, v, d);
      check("t2_stall_cycles", st, 0);
      check("t2_mem_rd_cnt", rds, 0);
      check("t2_rsp_valid", v, 1);
      check("t2_rdata", d, init_word(3));

      // 3: write hit with backing memory busy for two cycles
      ready_block = 2;
      do_req(1'b1, 16'h0003, 16'hABCD, st, rds, wrs, v, d);
      check("t3_stall_cycles", st, 2);
      check("t3_mem_wr_cnt", wrs, 1);
      check("t3_no_rsp", v, 0);
      check("t3_mem_word", tb_mem[16'h0003], 16'hABCD);
      do_req(1'b0, 16'h0003, 16'h0, st, rds, wrs, v, d);
      check("t3_rd_stall", st, 0);
      check("t3_rd_mem_rd", rds, 0);
      check("t3_rd_rdata", d, 16'hABCD);

      // 4: write miss does not allocate
      do_req(1'b1, 16'h0400, 16'h1234, st, rds, wrs, v, d);
      check("t4_stall_cycles", st, 0);
      check("t4_mem_wr_cnt", wrs, 1);
      check("t4_mem_rd_cnt", rds, 0);
      do_req(1'b0, 16'h0400, 16'h0, st, rds, wrs, v, d);
      check("t4_rd_mem_rd", rds, 8);
      check("t4_rd_first", first_rd_addr, 16'h0400);
      check("t4_rd_stall", st, 13);
      check("t4_rd_rdata", d, 16'h1234);

      // 5: conflict eviction on index 0
      do_req(1'b0, 16'h0000, 16'h0, st, rds, wrs, v, d);
      check("t5_a_mem_rd", rds, 8);
      check("t5_a_rdata", d, init_word(0));
      do_req(1'b0, 16'h0200, 16'h0, st, rds, wrs, v, d);
      check("t5_b_mem_rd", rds, 8);
      check("t5_b_last", last_rd_addr, 16'h0207);
      check("t5_b_rdata", d, init_word(16'h0200));
      do_req(1'b0, 16'h0000, 16'h0, st, rds, wrs, v, d);
      check("t5_c_mem_rd", rds, 8);
      check("t5_c_rdata", d, init_word(0));

`ifdef CACHE_STATS_EN
      check("stats_hit_cnt", hit_cnt, 7);
      check("stats_miss_cnt", miss_cnt, 5);
`endif

      // 6: reset in the middle of a fill
      n_ret = 0; guard = 0;
      cyc_begin();
      req_en = 1'b1; req_we = 1'b0; req_addr = 16'h0801;
      cyc_end();
      while (n_ret < 3 && guard < 50) begin
         guard++;
         cyc_begin();
         cyc_end();
      end
      check("t6_three_returns", n_ret, 3);
      check("t6_fill_stall", stall, 1);
      cyc_begin();
      rst_n = 1'b0; req_en = 1'b0;
      cyc_end();
      check("t6_rst_stall", stall, 0);
      check("t6_rst_mem_rd", mem_rd, 0);
      cyc_begin();
      rst_n = 1'b1;
      cyc_end();
      for (int i = 0; i < 10; i++) begin
         cyc_begin();
         cyc_end();
         check("t6_idle_no_rd", mem_rd, 0);
      end
      do_req(1'b0, 16'h0801, 16'h0, st, rds, wrs, v, d);
      check("t6_refill_rd", rds, 8);
      check("t6_refill_first", first_rd_addr, 16'h0800);
      check("t6_refill_stall", st, 13);
      check("t6_rdata", d, init_word(16'h0801));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
